fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage of the RV32I core. Owns the program counter and drives the word address into the instruction memory, which has a combinational read. Latches the returned instruction word into the IF/ID pipeline register. Handles decode stalls, EX-stage redirects (branch/jal/jalr) with bubble insertion, halting on ECALL/EBREAK, and fetches beyond the populated memory.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
ADDR_W, 8, width of the instruction-memory word address
MEM_WORDS, 71, number of populated memory words; a PC with word index >= MEM_WORDS faults
NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold the PC and the IF/ID register (hazard unit)
redirect  in  1  control transfer resolved in EX
redirect_target  in  32  byte address of the new PC
imem_addr  out  ADDR_W  word address to instruction memory, equal to pc[ADDR_W+1:2]
imem_data  in  32  instruction word from memory (combinational)
pc_out  out  32  current fetch PC
ifid_pc  out  32  PC of the latched instruction
ifid_pc_plus4  out  32  ifid_pc + 4
ifid_instr  out  32  latched instruction
ifid_valid  out  1  latched instruction is real (1) or a bubble (0)
halted  out  1  fetch frozen by ECALL/EBREAK or a fault
fetch_fault  out  1  sticky; set on a fetch with word index >= MEM_WORDS

Behaviour:
- One clock. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- imem_addr is combinational from pc. Memory read latency is 0, so the instruction is captured in the same cycle its address is presented.
- Define `exc` as true when imem_data == 32'h00000073 (ECALL) or imem_data == 32'h00100073 (EBREAK).
- Define `oor` as true when pc[31:2] >= MEM_WORDS.
- Per-edge priority, highest first:
  1. rst: pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus4=4, ifid_valid=0, halted=0, fetch_fault=0.
  2. redirect: pc={redirect_target[31:2],2'b00}, so the low two bits are dropped silently. Load a bubble into IF/ID (ifid_instr=NOP_INSTR, ifid_valid=0; ifid_pc and ifid_pc_plus4 hold). Clear halted and fetch_fault. Redirect overrides stall and halted, because a halting instruction may be on a wrong path.
  3. stall: pc and all ifid_* hold.
  4. halted: pc holds. Load a bubble into IF/ID.
  5. oor: pc holds. Load a bubble into IF/ID. Set halted=1 and fetch_fault=1. imem_data is ignored, even if it is X.
  6. normal: ifid_instr=imem_data, ifid_pc=pc, ifid_pc_plus4=pc+4, ifid_valid=1, pc=pc+4. If exc, also set halted=1; the halting instruction itself is delivered with valid=1.
- Arithmetic: pc+4 wraps modulo 2^32. imem_addr wraps modulo 2^ADDR_W. With the default parameters oor triggers first, so wrap is never reached.
- Mid-operation reset: takes effect on the next edge regardless of stall, redirect or halted.
- Outputs are registered, except imem_addr and pc_out, which are direct views of the PC register.

Test Plan:
- Reset then run: rst high for 2 cycles, then low for 3 cycles with memory loaded with the standard program. Required: imem_addr=0 during reset and ifid_valid=0. After the 3rd edge, ifid_instr=0x00500113, ifid_pc=8, pc_out=12.
- Stall: stall=1 for 2 cycles at pc_out=12. Required: pc_out stays 12 and ifid_instr stays 0x00500113. On release, the next capture is 0x01400193 at ifid_pc=12.
- Redirect with simultaneous stall: redirect=1, redirect_target=0xD4, stall=1. Required: pc_out=0xD4, ifid_valid=0, ifid_instr=0x00000013. The next edge latches 0x00000863 with ifid_pc=0xD4.
- Halt: redirect to 0xF8 (EBREAK). Required, next edge: ifid_instr=0x00100073, ifid_valid=1, halted=1, pc_out=0xFC. Subsequent edges give ifid_valid=0 and pc_out=0xFC. A redirect to 0 clears halted and restarts fetch.
- Fault and misalignment: redirect_target=0x122. Required: pc_out=0x120. The next edge gives fetch_fault=1, halted=1, ifid_valid=0, and pc holds 0x120. A redirect to 0x106 then gives pc_out=0x104 and fetch_fault=0.
- Reset during halt: assert rst while halted=1 and fetch_fault=1. Required after one edge: both flags are 0, pc_out=RESET_PC and ifid_valid=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: control in, instruction-memory bus, and the IF/ID register view.
interface fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              stall;
    logic              redirect;
    logic [31:0]       redirect_target;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       pc_out;
    logic [31:0]       ifid_pc;
    logic [31:0]       ifid_pc_plus4;
    logic [31:0]       ifid_instr;
    logic              ifid_valid;
    logic              halted;
    logic              fetch_fault;

    modport master (
        input  stall, redirect, redirect_target, imem_data,
        output imem_addr, pc_out, ifid_pc, ifid_pc_plus4, ifid_instr,
               ifid_valid, halted, fetch_fault
    );

    modport slave (
        output stall, redirect, redirect_target, imem_data,
        input  imem_addr, pc_out, ifid_pc, ifid_pc_plus4, ifid_instr,
               ifid_valid, halted, fetch_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch: PC + IF/ID register, zero-latency imem read captured on the same edge.
// Stall holds PC and IF/ID; redirect overrides stall/halt and inserts a bubble.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_W    = 8,
    parameter int          MEM_WORDS = 71,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_FAULT
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    state_t      state_q, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    ifid_t       ifid_q, ifid_nxt;

    logic exc;
    logic oor;
    logic unused_tgt_bits;

    assign exc = (bus.imem_data == 32'h0000_0073) || (bus.imem_data == 32'h0010_0073);
    assign oor = {2'b00, pc_q[31:2]} >= 32'(MEM_WORDS);
    assign unused_tgt_bits = ^bus.redirect_target[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            ifid_q  <= '{pc: 32'd0, pc_plus4: 32'd4, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            ifid_q  <= ifid_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        ifid_nxt  = ifid_q;
        if (bus.redirect) begin
            // A halting instruction may sit on a wrong path, so redirect always restarts fetch.
            pc_nxt         = {bus.redirect_target[31:2], 2'b00};
            ifid_nxt.instr = NOP_INSTR;
            ifid_nxt.valid = 1'b0;
            state_nxt      = ST_RUN;
        end else if (bus.stall) begin
            state_nxt = state_q;
        end else if (state_q != ST_RUN) begin
            ifid_nxt.instr = NOP_INSTR;
            ifid_nxt.valid = 1'b0;
        end else if (oor) begin
            ifid_nxt.instr = NOP_INSTR;
            ifid_nxt.valid = 1'b0;
            state_nxt      = ST_FAULT;
        end else begin
            ifid_nxt = '{pc: pc_q, pc_plus4: pc_q + 32'd4, instr: bus.imem_data, valid: 1'b1};
            pc_nxt   = pc_q + 32'd4;
            if (exc) begin
                state_nxt = ST_HALT;
            end
        end
    end

    assign bus.imem_addr     = pc_q[ADDR_W+1:2];
    assign bus.pc_out        = pc_q;
    assign bus.ifid_pc       = ifid_q.pc;
    assign bus.ifid_pc_plus4 = ifid_q.pc_plus4;
    assign bus.ifid_instr    = ifid_q.instr;
    assign bus.ifid_valid    = ifid_q.valid;
    assign bus.halted        = (state_q != ST_RUN);
    assign bus.fetch_fault   = (state_q == ST_FAULT);
endmodule
